mem_access_unit: RTL

// Parametrised MAR/MDR memory-access controller between the control unit and the RAM.

---
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mem_access_unit.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Bus bundle between the control unit / RAM side and the memory-access unit.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              req;
  logic              we;
  logic              fetch;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] instr;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Control unit and RAM model side
  modport master (
    output req, we, fetch, pc_in, addr_in, wdata, mem_rdata,
    input  busy, done, err, mar, rdata, instr, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Memory-access unit side
  modport slave (
    input  req, we, fetch, pc_in, addr_in, wdata, mem_rdata,
    output busy, done, err, mar, rdata, instr, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MAR/MDR memory-access controller: latches a fetch or data address, runs a multi-cycle
// RAM read/write with configurable wait states and returns data to instr or rdata.
module mem_access_unit #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic               clk,
  input logic               rst,
  mem_access_unit_if.slave  bus
);

  localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              fetch_q;
  logic              wr_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [ADDR_W-1:0] acc_addr;
  logic              acc_wr;
  logic              acc_oor;

  assign acc_addr = bus.fetch ? bus.pc_in : bus.addr_in;
  // A fetch is always a read, whatever we says
  assign acc_wr   = bus.we & ~bus.fetch;
  // One extra bit so MEM_DEPTH == 2**ADDR_W is representable
  assign acc_oor  = {1'b0, acc_addr} >= (ADDR_W + 1)'(MEM_DEPTH);

  // Access sequencer: accept in IDLE/DONE, hold ACCESS for WAIT_CYCLES+1 cycles, pulse DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      fetch_q  <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mar_q    <= '0;
      rdata_q  <= '0;
      instr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.req) begin
            mar_q   <= acc_addr;
            fetch_q <= bus.fetch;
            wr_q    <= acc_wr;
            wdata_q <= bus.wdata;
            cnt_q   <= CntW'(WAIT_CYCLES);
            if (acc_oor) begin
              // No RAM cycle: report completion with error straight away
              state_q  <= StDone;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
              mem_en_q <= 1'b0;
              mem_we_q <= 1'b0;
            end else begin
              state_q  <= StAccess;
              busy_q   <= 1'b1;
              done_q   <= 1'b0;
              err_q    <= 1'b0;
              mem_en_q <= 1'b1;
              mem_we_q <= acc_wr;
            end
          end else begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        StAccess: begin
          if (cnt_q == '0) begin
            state_q  <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (!wr_q) begin
              if (fetch_q) instr_q <= bus.mem_rdata;
              else         rdata_q <= bus.mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mar       = mar_q;
  assign bus.rdata     = rdata_q;
  assign bus.instr     = instr_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mar_q;
  assign bus.mem_wdata = wdata_q;

endmodule
